// File: rtl/puzzle_scheduler.sv
// Alarm puzzle scheduler: on an alarm, hands puzzles round-robin to three
// equation blocks, times each one out, and dismisses the alarm after
// REQUIRED_SOLVES consecutive correct answers.
module puzzle_scheduler #(
    parameter int unsigned REQUIRED_SOLVES = 3,
    parameter int unsigned TIMEOUT_SEC     = 30
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       alarm_trigger,
    input  logic       sec_tick,
    input  logic [2:0] eq_done,
    input  logic [2:0] eq_correct,
    output logic [2:0] eq_start,
    output logic [2:0] eq_abort,
    output logic [6:0] ongoing_timer,
    output logic [2:0] solved_count,
    output logic       alarm_on,
    output logic       dismissed
);

    localparam logic [2:0] SolveTarget = 3'(REQUIRED_SOLVES);
    localparam logic [6:0] TimeoutLoad = 7'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StRun,
        StEval,
        StAbort,
        StDismiss
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic       captured;

    logic [2:0] next_count;
    logic [1:0] ptr_next;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Count after the current evaluation and the round-robin successor of ptr.
    always_comb begin
        next_count = captured ? solved_count + 3'd1 : 3'd0;
        ptr_next   = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    end

    // Scheduler FSM; every output is a register updated alongside the state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= StIdle;
            ptr           <= 2'd0;
            sel           <= 2'd0;
            captured      <= 1'b0;
            eq_start      <= 3'b000;
            eq_abort      <= 3'b000;
            ongoing_timer <= 7'd0;
            solved_count  <= 3'd0;
            alarm_on      <= 1'b0;
            dismissed     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (alarm_trigger) begin
                        alarm_on <= 1'b1;
                        state    <= StSelect;
                    end
                end
                StSelect: begin
                    ongoing_timer <= TimeoutLoad;
                    sel           <= ptr;
                    eq_start      <= onehot(ptr);
                    state         <= StRun;
                end
                StRun: begin
                    if (sec_tick && ongoing_timer != 7'd0) begin
                        ongoing_timer <= ongoing_timer - 7'd1;
                    end
                    // A finished answer beats an expired timer.
                    if (eq_done[sel]) begin
                        captured <= eq_correct[sel];
                        eq_start <= 3'b000;
                        state    <= StEval;
                    end else if (ongoing_timer == 7'd0) begin
                        eq_start <= 3'b000;
                        eq_abort <= onehot(sel);
                        state    <= StAbort;
                    end
                end
                StAbort: begin
                    eq_abort     <= 3'b000;
                    solved_count <= 3'd0;
                    ptr          <= ptr_next;
                    state        <= StSelect;
                end
                StEval: begin
                    solved_count <= next_count;
                    ptr          <= ptr_next;
                    if (next_count == SolveTarget) begin
                        dismissed <= 1'b1;
                        state     <= StDismiss;
                    end else begin
                        state <= StSelect;
                    end
                end
                StDismiss: begin
                    dismissed     <= 1'b0;
                    alarm_on      <= 1'b0;
                    solved_count  <= 3'd0;
                    ongoing_timer <= 7'd0;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
